// File: rtl/output_arbiter_if.sv
// Purpose : bundles the requester-side inputs and display-side outputs of output_arbiter.
// Latency : n/a (wiring only).
// Backpressure: n/a; requesters hold i_REQ until their o_ACK bit pulses.
//
// Signals:
//   i_REQ      per-requester request, held until the matching o_ACK bit is seen
//   i_DATA     requester k data at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_CLEAR    synchronous display clear, aborts any transfer in flight
//   o_ACK      one-cycle one-hot pulse to the requester whose value was loaded
//   o_BUS      data to the display's bus input
//   o_READ_BUS stretched load strobe for the display
//   o_CLEAR_n  active-low display clear
//   o_OWNER    index of the current or last grant
//   o_BUSY     high while a value is being loaded or dwelling
// Modports: master = requester/driver side, slave = arbiter side.
interface output_arbiter_if #(
    parameter int DATA_WIDTH = 8
);
    logic [3:0]              i_REQ;
    logic [4*DATA_WIDTH-1:0] i_DATA;
    logic                    i_CLEAR;
    logic [3:0]              o_ACK;
    logic [DATA_WIDTH-1:0]   o_BUS;
    logic                    o_READ_BUS;
    logic                    o_CLEAR_n;
    logic [1:0]              o_OWNER;
    logic                    o_BUSY;

    modport master (
        output i_REQ, i_DATA, i_CLEAR,
        input  o_ACK, o_BUS, o_READ_BUS, o_CLEAR_n, o_OWNER, o_BUSY
    );

    modport slave (
        input  i_REQ, i_DATA, i_CLEAR,
        output o_ACK, o_BUS, o_READ_BUS, o_CLEAR_n, o_OWNER, o_BUSY
    );
endinterface

// File: rtl/output_arbiter.sv
// Purpose : round-robin share of one seven-segment display between four requesters.
// Latency : grant one edge after a request is seen in IDLE; ack in the last of max(HOLD_CYCLES,1) load cycles.
// Backpressure: requests wait in IDLE; nothing is granted during LOAD/DWELL or while i_CLEAR is high.
//
// Ports:
//   i_SYS_CLOCK  system clock, all logic on the posedge
//   i_RESET_n    asynchronous active-low reset
//   arb          output_arbiter_if.slave carrying requests, data, clear and all display-side outputs
//
// Flow: IDLE -> (grant) LOAD for the hold time with o_READ_BUS high -> DWELL for the
// dwell time with o_BUS held -> IDLE. i_CLEAR overrides every state and returns to IDLE.
module output_arbiter #(
    parameter int          DATA_WIDTH   = 8,
    parameter logic [31:0] HOLD_CYCLES  = 32'h0001_0000,
    parameter logic [31:0] DWELL_CYCLES = 32'h02FA_F080
) (
    input  logic             i_SYS_CLOCK,
    input  logic             i_RESET_n,
    output_arbiter_if.slave  arb
);

    // A zero hold would leave no cycle for the strobe or the ack, so it is promoted to one.
    localparam logic [31:0] HOLD_EFF = (HOLD_CYCLES == 32'd0) ? 32'd1 : HOLD_CYCLES;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DWELL = 2'd2
    } state_t;

    state_t                state_q,   state_d;
    logic [31:0]           cnt_q,     cnt_d;
    logic [1:0]            ptr_q,     ptr_d;
    logic [3:0]            ack_q,     ack_d;
    logic [DATA_WIDTH-1:0] bus_q,     bus_d;
    logic                  read_q,    read_d;
    logic                  clear_n_q, clear_n_d;
    logic [1:0]            owner_q,   owner_d;
    logic                  busy_q,    busy_d;

    // Round-robin pick: search upward from ptr+1, wrapping, so the last winner is
    // considered last.
    logic       gnt_vld;
    logic [1:0] gnt_idx;

    always_comb begin
        logic [1:0] cand;
        gnt_vld = 1'b0;
        gnt_idx = ptr_q;
        cand    = ptr_q;
        for (int i = 1; i <= 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!gnt_vld && arb.i_REQ[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        ack_d     = 4'b0000;
        bus_d     = bus_q;
        read_d    = read_q;
        clear_n_d = 1'b1;
        owner_d   = owner_q;
        busy_d    = busy_q;

        if (arb.i_CLEAR) begin
            // Abort: no ack, pointer untouched so the aborted requester keeps its turn.
            state_d   = ST_IDLE;
            read_d    = 1'b0;
            busy_d    = 1'b0;
            bus_d     = '0;
            clear_n_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (gnt_vld) begin
                        state_d = ST_LOAD;
                        cnt_d   = HOLD_EFF;
                        bus_d   = arb.i_DATA[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
                        owner_d = gnt_idx;
                        read_d  = 1'b1;
                        busy_d  = 1'b1;
                        // With a one-cycle load the first LOAD cycle is also the last.
                        if (HOLD_EFF == 32'd1) begin
                            ack_d = 4'b0001 << gnt_idx;
                        end
                    end
                end

                ST_LOAD: begin
                    if (cnt_q <= 32'd1) begin
                        ptr_d  = owner_q;
                        read_d = 1'b0;
                        if (DWELL_CYCLES != 32'd0) begin
                            state_d = ST_DWELL;
                            cnt_d   = DWELL_CYCLES;
                        end else begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q - 32'd1;
                        // Counter reaches 1 on the next edge: that cycle is the final LOAD cycle.
                        if (cnt_q == 32'd2) begin
                            ack_d = 4'b0001 << owner_q;
                        end
                    end
                end

                ST_DWELL: begin
                    if (cnt_q <= 32'd1) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 32'd1;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    read_d  = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // Pointer resets to 3 so requester 0 wins the first arbitration.
    // o_CLEAR_n resets low and rises on the first edge after release, clearing the display.
    always_ff @(posedge i_SYS_CLOCK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 32'd0;
            ptr_q     <= 2'd3;
            ack_q     <= 4'b0000;
            bus_q     <= '0;
            read_q    <= 1'b0;
            clear_n_q <= 1'b0;
            owner_q   <= 2'd0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            ack_q     <= ack_d;
            bus_q     <= bus_d;
            read_q    <= read_d;
            clear_n_q <= clear_n_d;
            owner_q   <= owner_d;
            busy_q    <= busy_d;
        end
    end

    assign arb.o_ACK      = ack_q;
    assign arb.o_BUS      = bus_q;
    assign arb.o_READ_BUS = read_q;
    assign arb.o_CLEAR_n  = clear_n_q;
    assign arb.o_OWNER    = owner_q;
    assign arb.o_BUSY     = busy_q;

    // Structural invariants of the grant/ack path.
    a_ack_onehot : assert property (@(posedge i_SYS_CLOCK) disable iff (!i_RESET_n)
        $onehot0(ack_q));
    a_ack_in_load : assert property (@(posedge i_SYS_CLOCK) disable iff (!i_RESET_n)
        (ack_q != 4'b0000) |-> (read_q && state_q == ST_LOAD && ack_q == (4'b0001 << owner_q)));
    a_busy_state : assert property (@(posedge i_SYS_CLOCK) disable iff (!i_RESET_n)
        busy_q == (state_q != ST_IDLE));

endmodule

// File: tb/tb_output_arbiter.sv
// Purpose : directed self-checking bench for output_arbiter (HOLD=4/DWELL=8, plus a HOLD=0/DWELL=0 instance).
// Latency : inputs driven and outputs sampled on the falling edge, half a cycle from the active edge.
// Backpressure: bench requesters drop i_REQ as soon as they observe their o_ACK bit.
module tb_output_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    always #5 clk = ~clk;

    output_arbiter_if #(.DATA_WIDTH(8)) ifa ();
    output_arbiter_if #(.DATA_WIDTH(8)) ifz ();

    output_arbiter #(
        .DATA_WIDTH  (8),
        .HOLD_CYCLES (32'd4),
        .DWELL_CYCLES(32'd8)
    ) u_dut (
        .i_SYS_CLOCK(clk),
        .i_RESET_n  (rst_n),
        .arb        (ifa)
    );

    output_arbiter #(
        .DATA_WIDTH  (8),
        .HOLD_CYCLES (32'd0),
        .DWELL_CYCLES(32'd0)
    ) u_zero (
        .i_SYS_CLOCK(clk),
        .i_RESET_n  (rst_n),
        .arb        (ifz)
    );

    task automatic do_reset();
        rst_n = 1'b0;
        ifa.i_REQ = 4'b0; ifa.i_CLEAR = 1'b0;
        ifz.i_REQ = 4'b0; ifz.i_CLEAR = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Waits for the next ack on the main instance; returns zeros if none arrives in budget.
    task automatic wait_ack(input int budget, output logic [3:0] ack,
                            output logic [7:0] bus, output logic [1:0] owner);
        ack = 4'b0; bus = 8'h00; owner = 2'd0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ifa.o_ACK !== 4'b0) begin
                ack   = ifa.o_ACK;
                bus   = ifa.o_BUS;
                owner = ifa.o_OWNER;
                ifa.i_REQ = ifa.i_REQ & ~ack;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output logic idle);
        idle = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ifa.o_BUSY === 1'b0) begin
                idle = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifa.i_REQ = 4'b0; ifa.i_DATA = '0; ifa.i_CLEAR = 1'b0;
        ifz.i_REQ = 4'b0; ifz.i_DATA = '0; ifz.i_CLEAR = 1'b0;
        repeat (2) @(negedge clk);
        vec_cnt++; if (ifa.o_CLEAR_n !== 1'b0) begin err_cnt++; $display("FAIL reset_clear_n: got %b want 0", ifa.o_CLEAR_n); end
        vec_cnt++; if (ifa.o_ACK !== 4'b0) begin err_cnt++; $display("FAIL reset_ack: got %b want 0000", ifa.o_ACK); end
        vec_cnt++; if (ifa.o_BUS !== 8'h00) begin err_cnt++; $display("FAIL reset_bus: got %h want 00", ifa.o_BUS); end
        vec_cnt++; if (ifa.o_READ_BUS !== 1'b0) begin err_cnt++; $display("FAIL reset_read: got %b want 0", ifa.o_READ_BUS); end
        vec_cnt++; if (ifa.o_OWNER !== 2'd0) begin err_cnt++; $display("FAIL reset_owner: got %0d want 0", ifa.o_OWNER); end
        vec_cnt++; if (ifa.o_BUSY !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b want 0", ifa.o_BUSY); end
        vec_cnt++; if (ifz.o_CLEAR_n !== 1'b0) begin err_cnt++; $display("FAIL reset_zero_clear_n: got %b want 0", ifz.o_CLEAR_n); end
        rst_n = 1'b1;
        @(negedge clk);
        vec_cnt++; if (ifa.o_CLEAR_n !== 1'b1) begin err_cnt++; $display("FAIL release_clear_n: got %b want 1", ifa.o_CLEAR_n); end
        vec_cnt++; if (ifz.o_CLEAR_n !== 1'b1) begin err_cnt++; $display("FAIL release_zero_clear_n: got %b want 1", ifz.o_CLEAR_n); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vec_cnt++; if (ifa.o_CLEAR_n !== 1'b1) begin err_cnt++; $display("FAIL idle_clear_n c=%0d: got %b want 1", c, ifa.o_CLEAR_n); end
            vec_cnt++; if (ifa.o_BUSY !== 1'b0) begin err_cnt++; $display("FAIL idle_busy c=%0d: got %b want 0", c, ifa.o_BUSY); end
        end
    endtask

    task automatic test_single();
        logic       exp_read, exp_busy;
        logic [3:0] exp_ack;
        ifa.i_DATA = {8'h00, 8'h00, 8'h5A, 8'h00};
        ifa.i_REQ  = 4'b0010;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            exp_read = (c < 4);
            exp_busy = (c < 12);
            exp_ack  = (c == 3) ? 4'b0010 : 4'b0000;
            if (c == 0) begin
                vec_cnt++; if (ifa.o_BUS !== 8'h5A) begin err_cnt++; $display("FAIL single_bus: got %h want 5a", ifa.o_BUS); end
                vec_cnt++; if (ifa.o_OWNER !== 2'd1) begin err_cnt++; $display("FAIL single_owner: got %0d want 1", ifa.o_OWNER); end
            end
            vec_cnt++; if (ifa.o_READ_BUS !== exp_read) begin err_cnt++; $display("FAIL single_read c=%0d: got %b want %b", c, ifa.o_READ_BUS, exp_read); end
            vec_cnt++; if (ifa.o_ACK !== exp_ack) begin err_cnt++; $display("FAIL single_ack c=%0d: got %b want %b", c, ifa.o_ACK, exp_ack); end
            vec_cnt++; if (ifa.o_BUSY !== exp_busy) begin err_cnt++; $display("FAIL single_busy c=%0d: got %b want %b", c, ifa.o_BUSY, exp_busy); end
            if (c == 1) ifa.i_DATA[15:8] = 8'hFF;
            if (c == 3) ifa.i_REQ = 4'b0000;
            if (c == 5) begin
                vec_cnt++; if (ifa.o_BUS !== 8'h5A) begin err_cnt++; $display("FAIL single_bus_held: got %h want 5a", ifa.o_BUS); end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] ack, exp_ack;
        logic [7:0] bus, exp_bus;
        logic [1:0] owner;
        logic       idle;
        int         order [2];
        ifa.i_DATA = {8'h13, 8'h12, 8'h11, 8'h10};
        ifa.i_REQ  = 4'hF;
        for (int n = 0; n < 4; n++) begin
            wait_ack(40, ack, bus, owner);
            exp_ack = 4'(1 << n);
            exp_bus = 8'(8'h10 + n);
            vec_cnt++; if (ack !== exp_ack) begin err_cnt++; $display("FAIL rr_ack n=%0d: got %b want %b", n, ack, exp_ack); end
            vec_cnt++; if (bus !== exp_bus) begin err_cnt++; $display("FAIL rr_bus n=%0d: got %h want %h", n, bus, exp_bus); end
            vec_cnt++; if (owner !== 2'(n)) begin err_cnt++; $display("FAIL rr_owner n=%0d: got %0d want %0d", n, owner, n); end
        end
        ifa.i_REQ = 4'b0101;
        order[0] = 0; order[1] = 2;
        for (int n = 0; n < 2; n++) begin
            wait_ack(40, ack, bus, owner);
            exp_ack = 4'(1 << order[n]);
            vec_cnt++; if (ack !== exp_ack) begin err_cnt++; $display("FAIL rr_pair_ack n=%0d: got %b want %b", n, ack, exp_ack); end
        end
        wait_idle(40, idle);
        vec_cnt++; if (idle !== 1'b1) begin err_cnt++; $display("FAIL rr_idle: got %b want 1", idle); end
    endtask

    task automatic test_clear_mid_load();
        logic [3:0] exp_ack;
        logic       idle;
        ifa.i_DATA = {8'h13, 8'h77, 8'h11, 8'h10};
        ifa.i_REQ  = 4'b0100;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            exp_ack = (c == 6) ? 4'b0100 : 4'b0000;
            vec_cnt++; if (ifa.o_ACK !== exp_ack) begin err_cnt++; $display("FAIL clr_ack c=%0d: got %b want %b", c, ifa.o_ACK, exp_ack); end
            if (c == 0) begin
                vec_cnt++; if (ifa.o_BUS !== 8'h77) begin err_cnt++; $display("FAIL clr_first_bus: got %h want 77", ifa.o_BUS); end
            end
            if (c == 1) ifa.i_CLEAR = 1'b1;
            if (c == 2) begin
                vec_cnt++; if (ifa.o_CLEAR_n !== 1'b0) begin err_cnt++; $display("FAIL clr_clear_n: got %b want 0", ifa.o_CLEAR_n); end
                vec_cnt++; if (ifa.o_BUS !== 8'h00) begin err_cnt++; $display("FAIL clr_bus: got %h want 00", ifa.o_BUS); end
                vec_cnt++; if (ifa.o_READ_BUS !== 1'b0) begin err_cnt++; $display("FAIL clr_read: got %b want 0", ifa.o_READ_BUS); end
                vec_cnt++; if (ifa.o_BUSY !== 1'b0) begin err_cnt++; $display("FAIL clr_busy: got %b want 0", ifa.o_BUSY); end
                ifa.i_CLEAR = 1'b0;
            end
            if (c == 3) begin
                vec_cnt++; if (ifa.o_CLEAR_n !== 1'b1) begin err_cnt++; $display("FAIL clr_clear_n_rise: got %b want 1", ifa.o_CLEAR_n); end
                vec_cnt++; if (ifa.o_READ_BUS !== 1'b1) begin err_cnt++; $display("FAIL clr_regrant_read: got %b want 1", ifa.o_READ_BUS); end
                vec_cnt++; if (ifa.o_BUS !== 8'h77) begin err_cnt++; $display("FAIL clr_regrant_bus: got %h want 77", ifa.o_BUS); end
                vec_cnt++; if (ifa.o_OWNER !== 2'd2) begin err_cnt++; $display("FAIL clr_regrant_owner: got %0d want 2", ifa.o_OWNER); end
            end
            if (c == 6) ifa.i_REQ = 4'b0000;
        end
        wait_idle(40, idle);
        vec_cnt++; if (idle !== 1'b1) begin err_cnt++; $display("FAIL clr_idle: got %b want 1", idle); end
    endtask

    task automatic test_dropped();
        logic [3:0] exp_ack;
        logic       exp_busy;
        ifa.i_DATA = {8'h13, 8'h77, 8'h11, 8'h31};
        ifa.i_REQ  = 4'b0001;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            exp_ack  = (c == 3) ? 4'b0001 : 4'b0000;
            exp_busy = (c < 12);
            vec_cnt++; if (ifa.o_ACK !== exp_ack) begin err_cnt++; $display("FAIL drop_ack c=%0d: got %b want %b", c, ifa.o_ACK, exp_ack); end
            vec_cnt++; if (ifa.o_OWNER !== 2'd0) begin err_cnt++; $display("FAIL drop_owner c=%0d: got %0d want 0", c, ifa.o_OWNER); end
            vec_cnt++; if (ifa.o_BUSY !== exp_busy) begin err_cnt++; $display("FAIL drop_busy c=%0d: got %b want %b", c, ifa.o_BUSY, exp_busy); end
            if (c == 0) ifa.i_REQ[3] = 1'b1;
            if (c == 2) ifa.i_REQ[3] = 1'b0;
            if (c == 3) ifa.i_REQ[0] = 1'b0;
        end
    endtask

    task automatic test_zero_params();
        logic [1:0] idx;
        logic [3:0] exp_ack;
        logic [7:0] exp_bus;
        ifz.i_DATA = {8'h00, 8'h00, 8'hA1, 8'hA0};
        ifz.i_REQ  = 4'b0011;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if ((c % 2) == 0) begin
                idx     = 2'((c / 2) % 2);
                exp_ack = 4'b0001 << idx;
                exp_bus = 8'hA0 + 8'(idx);
                vec_cnt++; if (ifz.o_ACK !== exp_ack) begin err_cnt++; $display("FAIL zero_ack c=%0d: got %b want %b", c, ifz.o_ACK, exp_ack); end
                vec_cnt++; if (ifz.o_READ_BUS !== 1'b1) begin err_cnt++; $display("FAIL zero_read c=%0d: got %b want 1", c, ifz.o_READ_BUS); end
                vec_cnt++; if (ifz.o_OWNER !== idx) begin err_cnt++; $display("FAIL zero_owner c=%0d: got %0d want %0d", c, ifz.o_OWNER, idx); end
                vec_cnt++; if (ifz.o_BUS !== exp_bus) begin err_cnt++; $display("FAIL zero_bus c=%0d: got %h want %h", c, ifz.o_BUS, exp_bus); end
            end else begin
                vec_cnt++; if (ifz.o_ACK !== 4'b0000) begin err_cnt++; $display("FAIL zero_gap_ack c=%0d: got %b want 0000", c, ifz.o_ACK); end
                vec_cnt++; if (ifz.o_READ_BUS !== 1'b0) begin err_cnt++; $display("FAIL zero_gap_read c=%0d: got %b want 0", c, ifz.o_READ_BUS); end
                vec_cnt++; if (ifz.o_BUSY !== 1'b0) begin err_cnt++; $display("FAIL zero_gap_busy c=%0d: got %b want 0", c, ifz.o_BUSY); end
            end
        end
        ifz.i_REQ = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_single();
        do_reset();
        test_round_robin();
        test_clear_mid_load();
        test_dropped();
        test_zero_params();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
